// File: rtl/health_anim_sequencer.sv
// Battle animation sequencer: attacker lunge, defender shake, then health-bar drain.
// Optional macro HEALTH_DRAIN_EN enables the frame-stepped drain; otherwise health tracks the clamped target.
module health_anim_sequencer #(
    parameter int         LUNGE_FRAMES = 8,
    parameter logic [9:0] LUNGE_PIX    = 10'd12,
    parameter int         SHAKE_FRAMES = 16,
    parameter logic [9:0] SHAKE_PIX    = 10'd4,
    parameter int         FRAME_DIV    = 2
) (
    input  logic       vgaclk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       animation_cmd_async,
    input  logic [6:0] target_health1,
    input  logic [6:0] target_health2,
    input  logic       p1_turn,
    input  logic       p2_turn,
    output logic [6:0] disp_health1,
    output logic [6:0] disp_health2,
    output logic [9:0] sprite1_xoff,
    output logic [9:0] sprite2_xoff,
    output logic       busy,
    output logic       anim_done
);

    typedef enum logic [2:0] {S_IDLE, S_ATTACK, S_SHAKE, S_DRAIN, S_DONE} state_t;

    localparam int CNT_MAX = (LUNGE_FRAMES > SHAKE_FRAMES) ? LUNGE_FRAMES : SHAKE_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
    logic             trig_q, trig_d;
    logic             atk_p1_q, atk_p1_d;
    logic [6:0]       disp_health1_q, disp_health1_d, disp_health2_q, disp_health2_d;
    logic [9:0]       sprite1_xoff_q, sprite1_xoff_d, sprite2_xoff_q, sprite2_xoff_d;
    logic             busy_q, busy_d, anim_done_q, anim_done_d;
    logic [6:0]       tgt1, tgt2;

`ifdef HEALTH_DRAIN_EN
    localparam int DIV_W = $clog2(FRAME_DIV + 1);
    logic [DIV_W-1:0] div_q, div_d;
    logic             match, drain_run;

    function automatic logic [6:0] step_toward(input logic [6:0] cur, input logic [6:0] tgt);
        if (cur < tgt)      return cur + 7'd1;
        else if (cur > tgt) return cur - 7'd1;
        else                return cur;
    endfunction
`endif

    always_comb begin
        tgt1 = (target_health1 > 7'd100) ? 7'd100 : target_health1;
        tgt2 = (target_health2 > 7'd100) ? 7'd100 : target_health2;

        sync1_d     = animation_cmd_async;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        trig_d      = sync2_q & ~sync3_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        atk_p1_d    = atk_p1_q;
        anim_done_d = 1'b0;
`ifdef HEALTH_DRAIN_EN
        match = (disp_health1_q == tgt1) && (disp_health2_q == tgt2);
`endif

        case (state_q)
            S_IDLE: begin
                // A trigger coinciding with frame_start enters ATTACK without counting that frame.
                if (trig_q && (p1_turn || p2_turn)) begin
                    state_d  = S_ATTACK;
                    cnt_d    = '0;
                    atk_p1_d = p1_turn;
                end
            end
            S_ATTACK: begin
                if (frame_start) begin
                    if (cnt_q == CNT_W'(LUNGE_FRAMES - 1)) begin
                        state_d = S_SHAKE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_SHAKE: begin
                if (frame_start) begin
                    if (cnt_q == CNT_W'(SHAKE_FRAMES - 1)) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
`ifdef HEALTH_DRAIN_EN
                if (frame_start && match) state_d = S_DONE;
`else
                if (frame_start) state_d = S_DONE;
`endif
            end
            S_DONE: begin
                state_d     = S_IDLE;
                anim_done_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

`ifdef HEALTH_DRAIN_EN
        // Engine runs only while resting in IDLE or DRAIN; it is paused on any transition.
        drain_run      = ((state_q == S_IDLE) && (state_d == S_IDLE)) ||
                         ((state_q == S_DRAIN) && (state_d == S_DRAIN));
        div_d          = div_q;
        disp_health1_d = disp_health1_q;
        disp_health2_d = disp_health2_q;
        if ((state_q == S_SHAKE) && (state_d == S_DRAIN)) begin
            div_d = '0;
        end else if (drain_run && frame_start) begin
            if (div_q == DIV_W'(FRAME_DIV - 1)) begin
                div_d          = '0;
                disp_health1_d = step_toward(disp_health1_q, tgt1);
                disp_health2_d = step_toward(disp_health2_q, tgt2);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
`else
        disp_health1_d = tgt1;
        disp_health2_d = tgt2;
`endif

        busy_d         = (state_d != S_IDLE);
        sprite1_xoff_d = '0;
        sprite2_xoff_d = '0;
        if (state_d == S_ATTACK) begin
            if (atk_p1_d) sprite1_xoff_d = LUNGE_PIX;
            else          sprite2_xoff_d = ~LUNGE_PIX + 10'd1;
        end else if (state_d == S_SHAKE) begin
            if (atk_p1_d) sprite2_xoff_d = cnt_d[0] ? (~SHAKE_PIX + 10'd1) : SHAKE_PIX;
            else          sprite1_xoff_d = cnt_d[0] ? (~SHAKE_PIX + 10'd1) : SHAKE_PIX;
        end
    end

    always_ff @(posedge vgaclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            sync3_q        <= 1'b0;
            trig_q         <= 1'b0;
            atk_p1_q       <= 1'b0;
            disp_health1_q <= 7'd100;
            disp_health2_q <= 7'd100;
            sprite1_xoff_q <= '0;
            sprite2_xoff_q <= '0;
            busy_q         <= 1'b0;
            anim_done_q    <= 1'b0;
`ifdef HEALTH_DRAIN_EN
            div_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            sync3_q        <= sync3_d;
            trig_q         <= trig_d;
            atk_p1_q       <= atk_p1_d;
            disp_health1_q <= disp_health1_d;
            disp_health2_q <= disp_health2_d;
            sprite1_xoff_q <= sprite1_xoff_d;
            sprite2_xoff_q <= sprite2_xoff_d;
            busy_q         <= busy_d;
            anim_done_q    <= anim_done_d;
`ifdef HEALTH_DRAIN_EN
            div_q          <= div_d;
`endif
        end
    end

    assign disp_health1 = disp_health1_q;
    assign disp_health2 = disp_health2_q;
    assign sprite1_xoff = sprite1_xoff_q;
    assign sprite2_xoff = sprite2_xoff_q;
    assign busy         = busy_q;
    assign anim_done    = anim_done_q;

endmodule
